// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register-file defaults, sequencer state
// encoding and the index of the hardwired zero register.
package cpu_pkg;
   localparam int RF_WIDTH = 32;
   localparam int RF_DEPTH = 32;

   localparam logic [0:0] RF_CLEAR = 1'b0;
   localparam logic [0:0] RF_RUN   = 1'b1;

   localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_read_mux.sv
// One register-file read port: range guard, zero register, same-cycle
// write forwarding, then the stored entry, in that priority order.
module rf_read_mux
   import cpu_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             i_run,
   input  logic [AW-1:0]    i_rn,
   input  logic             i_w,
   input  logic [AW-1:0]    i_wn,
   input  logic [WIDTH-1:0] i_wd,
   input  logic [WIDTH-1:0] i_mem [DEPTH],
   output logic [WIDTH-1:0] o_rd
);
   logic w_in_range;
   logic w_is_zero;
   logic w_fwd;

   // A power-of-two depth leaves no unreachable addresses to guard against.
   generate
      if (DEPTH == (1 << AW)) begin : g_full
         assign w_in_range = 1'b1;
      end else begin : g_partial
         assign w_in_range = (32'(i_rn) < 32'(DEPTH));
      end
   endgenerate

   assign w_is_zero = ZERO_REG && (i_rn == AW'(RF_ZERO_IDX));
   assign w_fwd     = BYPASS && i_w && (i_wn == i_rn);

   always_comb begin
      o_rd = '0;
      if (!i_run || !w_in_range || w_is_zero) begin
         o_rd = '0;
      end else if (w_fwd) begin
         o_rd = i_wd;
      end else begin
         o_rd = i_mem[i_rn];
      end
   end
endmodule

// File: rtl/rf_param.sv
// Parametrised two-read/one-write register file with a self-clearing
// reset sequencer; reads are combinational, the write commits on clk.
module rf_param
   import cpu_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    rn1,
   input  logic [AW-1:0]    rn2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic [AW-1:0]    wn,
   input  logic [WIDTH-1:0] wd,
   input  logic             w,
   output logic             ready
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [0:0]       r_state;
   logic [AW-1:0]    r_cnt;
   logic             r_ready;

   logic w_run;
   logic w_wn_in_range;
   logic w_wr_ok;

   generate
      if (DEPTH == (1 << AW)) begin : g_wfull
         assign w_wn_in_range = 1'b1;
      end else begin : g_wpartial
         assign w_wn_in_range = (32'(wn) < 32'(DEPTH));
      end
   endgenerate

   assign w_run   = (r_state == RF_RUN);
   assign w_wr_ok = !reset && w_run && w && w_wn_in_range &&
                    !(ZERO_REG && (wn == AW'(RF_ZERO_IDX)));
   assign ready   = r_ready;

   // Counter parks on the last entry once the sweep finishes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RF_CLEAR;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else if (r_state == RF_CLEAR) begin
         if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
         end else begin
            r_cnt <= r_cnt + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (r_state == RF_CLEAR)) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wn] <= wd;
      end
   end

   rf_read_mux #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd1 (
      .i_run(w_run), .i_rn(rn1), .i_w(w), .i_wn(wn), .i_wd(wd),
      .i_mem(r_mem), .o_rd(rd1)
   );

   rf_read_mux #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd2 (
      .i_run(w_run), .i_rn(rn2), .i_w(w), .i_wn(wn), .i_wd(wd),
      .i_mem(r_mem), .o_rd(rd2)
   );
endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench for rf_param: three instances (bypass, no bypass,
// DEPTH=20) share stimulus; a negedge monitor drains expected values.
module tb_rf_param;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rn1, rn2, wn;
   logic [31:0] wd;
   logic        w;
   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
   logic        rdy_a, rdy_b, rdy_c;

   always #5 clk = ~clk;

   rf_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
      .clk(clk), .reset(reset), .rn1(rn1), .rn2(rn2), .rd1(rd1_a), .rd2(rd2_a),
      .wn(wn), .wd(wd), .w(w), .ready(rdy_a)
   );
   rf_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
      .clk(clk), .reset(reset), .rn1(rn1), .rn2(rn2), .rd1(rd1_b), .rd2(rd2_b),
      .wn(wn), .wd(wd), .w(w), .ready(rdy_b)
   );
   rf_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
      .clk(clk), .reset(reset), .rn1(rn1), .rn2(rn2), .rd1(rd1_c), .rd2(rd2_c),
      .wn(wn), .wd(wd), .w(w), .ready(rdy_c)
   );

   // sel = dut*3 + port, port 0 = rd1, 1 = rd2, 2 = ready; dut a=0 b=1 c=2
   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [31:0] actual(int sel);
      case (sel)
         0: return rd1_a;
         1: return rd2_a;
         2: return {31'd0, rdy_a};
         3: return rd1_b;
         4: return rd2_b;
         5: return {31'd0, rdy_b};
         6: return rd1_c;
         7: return rd2_c;
         8: return {31'd0, rdy_c};
         default: return 'x;
      endcase
   endfunction

   task automatic expect_val(int sel, logic [31:0] exp, string name);
      exp_t e;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (actual(e.sel) !== e.exp) begin
               failures++;
               $display("FAIL %s (sel %0d): got %h expected %h",
                        e.name, e.sel, actual(e.sel), e.exp);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; w = 1'b0; wn = '0; wd = '0; rn1 = 5'd5; rn2 = 5'd31;
      tick();
      expect_val(2, 0, "rst_ready_a");
      expect_val(5, 0, "rst_ready_b");
      expect_val(8, 0, "rst_ready_c");
      reset = 1'b0;

      for (int e = 1; e <= 32; e++) begin
         tick();
         expect_val(2, 32'(e == 32), $sformatf("clr_ready_a_e%0d", e));
         expect_val(5, 32'(e == 32), $sformatf("clr_ready_b_e%0d", e));
         expect_val(8, 32'(e >= 20), $sformatf("clr_ready_c_e%0d", e));
         if (e < 32) begin
            expect_val(0, 0, $sformatf("clr_rd1_a_e%0d", e));
            expect_val(1, 0, $sformatf("clr_rd2_a_e%0d", e));
         end
      end

      // i*i into every register; DEPTH=20 drops 20..31, register 0 stays 0
      w = 1'b1;
      for (int i = 0; i < 32; i++) begin
         wn = 5'(i);
         wd = 32'(i * i);
         tick();
      end
      w = 1'b0; rn1 = 5'd5; rn2 = 5'd31;
      expect_val(0, 25,  "sq_rd1_a");
      expect_val(1, 961, "sq_rd2_a");
      expect_val(3, 25,  "sq_rd1_b");
      expect_val(4, 961, "sq_rd2_b");
      expect_val(6, 25,  "sq_rd1_c");
      expect_val(7, 0,   "sq_rd2_c_oor");
      tick();
      rn1 = 5'd0; rn2 = 5'd12;
      expect_val(0, 0,   "zero_rd1_a");
      expect_val(3, 0,   "zero_rd1_b");
      expect_val(6, 0,   "zero_rd1_c");
      expect_val(1, 144, "r12_rd2_a");
      tick();

      w = 1'b1; wn = 5'd7; wd = 32'hDEAD_BEEF; rn1 = 5'd7; rn2 = 5'd8;
      expect_val(0, 32'hDEAD_BEEF, "byp_rd1_a");
      expect_val(3, 49,            "nobyp_rd1_b");
      expect_val(6, 32'hDEAD_BEEF, "byp_rd1_c");
      expect_val(1, 64,            "byp_rd2_a");
      expect_val(4, 64,            "nobyp_rd2_b");
      tick();
      w = 1'b0;
      expect_val(0, 32'hDEAD_BEEF, "post_rd1_a");
      expect_val(3, 32'hDEAD_BEEF, "post_rd1_b");
      expect_val(6, 32'hDEAD_BEEF, "post_rd1_c");
      tick();

      w = 1'b1; wn = 5'd0; wd = 32'd123; rn1 = 5'd0; rn2 = 5'd0;
      expect_val(0, 0, "zbyp_rd1_a");
      expect_val(6, 0, "zbyp_rd1_c");
      tick();
      w = 1'b0;
      expect_val(0, 0, "zwr_rd1_a");
      expect_val(4, 0, "zwr_rd2_b");
      expect_val(6, 0, "zwr_rd1_c");
      tick();

      w = 1'b1; wn = 5'd25; wd = 32'd5; rn1 = 5'd25; rn2 = 5'd19;
      expect_val(6, 0,   "oor_byp_rd1_c");
      expect_val(7, 361, "oor_rd2_c");
      expect_val(0, 5,   "w25_byp_rd1_a");
      expect_val(3, 625, "w25_old_rd1_b");
      tick();
      w = 1'b0;
      expect_val(6, 0,   "oor_post_rd1_c");
      expect_val(7, 361, "oor_post_rd2_c");
      expect_val(0, 5,   "w25_post_rd1_a");
      expect_val(3, 5,   "w25_post_rd1_b");
      tick();
      rn1 = 5'd18; rn2 = 5'd24;
      expect_val(6, 324, "r18_rd1_c");
      expect_val(7, 0,   "r24_rd2_c");
      expect_val(1, 576, "r24_rd2_a");
      tick();

      rn1 = 5'd12; rn2 = 5'd12;
      expect_val(0, 144, "same_rd1_a");
      expect_val(1, 144, "same_rd2_a");
      expect_val(3, 144, "same_rd1_b");
      expect_val(4, 144, "same_rd2_b");
      expect_val(6, 144, "same_rd1_c");
      expect_val(7, 144, "same_rd2_c");
      tick();

      // Reset again, then interrupt the sweep at count 10
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         expect_val(2, 0, $sformatf("mid_ready_a_e%0d", e));
      end
      reset = 1'b1; w = 1'b1; wn = 5'd3; wd = 32'd9; rn1 = 5'd3; rn2 = 5'd12;
      tick();
      reset = 1'b0;
      expect_val(2, 0, "rst2_ready_a");
      for (int e = 1; e <= 32; e++) begin
         tick();
         if (e == 19) w = 1'b0;
         expect_val(2, 32'(e == 32), $sformatf("clr2_ready_a_e%0d", e));
         expect_val(5, 32'(e == 32), $sformatf("clr2_ready_b_e%0d", e));
         expect_val(8, 32'(e >= 20), $sformatf("clr2_ready_c_e%0d", e));
         if (e < 32) expect_val(0, 0, $sformatf("clr2_rd1_a_e%0d", e));
      end
      expect_val(0, 0, "lost_rd1_a");
      expect_val(3, 0, "lost_rd1_b");
      expect_val(6, 0, "lost_rd1_c");
      expect_val(1, 0, "clr_r12_a");
      tick();

      w = 1'b1; wn = 5'd3; wd = 32'd9;
      tick();
      w = 1'b0;
      expect_val(0, 9, "rewr_rd1_a");
      expect_val(3, 9, "rewr_rd1_b");
      expect_val(6, 9, "rewr_rd1_c");
      tick();
      tick();

      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor to the two-read/one-write CPU register file.
- Width, depth and read-port behaviour are generic.
- Adds a self-clearing reset sequencer, hardwired zero register, optional write-to-read bypass and out-of-range address protection.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; need not be a power of two (min 2).
- AW, $clog2(DEPTH), address width (derived, not overridden).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the read output.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rn1  input  AW  read address, port 1.
- rn2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).
- wn  input  AW  write address.
- wd  input  WIDTH  write data.
- w  input  1  write enable.
- ready  output  1  high when clear sequence is complete and the file accepts writes.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset.
- State machine: CLEAR and RUN.
  - Rising edge with reset=1: state<=CLEAR, cnt<=0, ready<=0, from any state (reset mid-clear restarts at entry 0).
  - CLEAR, reset=0: mem[cnt]<=0 each edge, cnt<=cnt+1. On the edge that clears entry DEPTH-1, state<=RUN and ready<=1.
  - ready therefore rises on the DEPTH-th edge after reset deasserts. It stays 1 until the next reset.
- Reset value of outputs: ready=0. rd1 and rd2 read 0 while state=CLEAR, regardless of address.
- Write in RUN: on a rising edge with w=1, mem[wn]<=wd.
  - Ignored when ZERO_REG=1 and wn=0.
  - Ignored when wn>=DEPTH.
  - Ignored entirely in CLEAR; w is don't-care there.
- Read in RUN, combinational with zero latency. For each port, in priority order:
  1. rn>=DEPTH gives 0.
  2. ZERO_REG=1 and rn=0 gives 0.
  3. BYPASS=1 and w=1 and wn==rn gives wd (same-cycle forward).
  4. Otherwise mem[rn].
- BYPASS=0: a same-cycle write is visible on reads only after the edge.
- Both read ports may address the same register simultaneously; both return identical data.
- No arithmetic on data. cnt is AW bits wide and never exceeds DEPTH-1.
- Storage is a plain register array. There is no per-register reset other than the clear sequence.

Decomposition:
- Shared package cpu_pkg holds:
  - RF_WIDTH=32 and RF_DEPTH=32 defaults;
  - the state encoding (RF_CLEAR=1'b0, RF_RUN=1'b1);
  - the zero-register index constant.
- One sub-module is natural: rf_read_mux, instantiated once per read port. It implements the range / zero / bypass / array priority select, so ports are identical by construction.
- The sequencer and write logic live in rf_param.

Test Plan:
- Reset 1 cycle, then poll ready. ready=0 for edges 1..31 after reset release and ready=1 on edge 32 (DEPTH=32). rd1/rd2=0 throughout.
- Write i*i to register i for i=0..31 after ready, then read rn1=5, rn2=31. Required: rd1=25, rd2=961; register 0 reads 0 with ZERO_REG=1, and reads 0 after writing 0 in this test.
- BYPASS=1: hold w=1, wn=7, wd=32'hDEAD_BEEF, rn1=7 before the edge. Required: rd1=DEADBEEF combinationally. With BYPASS=0, rd1 keeps its old value (49) until after the edge.
- Assert reset for 1 cycle at clear count 10 (mid-sequence). Required: cnt restarts at 0 and ready rises exactly 32 edges after the second reset release. Writes attempted during CLEAR (wn=3, wd=9) are lost, so register 3 reads 0.
- DEPTH=20 instance: write wn=25, wd=5, then read rn1=25, rn2=19 (previously written 361). Required: rd1=0, rd2=361; no other register changes.
- Simultaneous reads: rn1=rn2=12 after writing 144. Required: rd1=rd2=144.
